control_logic_pipe: RTL and testbench

Three-stage pipelined RV32I integer ALU datapath controller. It accepts one 32-bit RISC-V instruction per clock, decodes R-type and I-type ALU operations, and reads operands from an externally supplied 32×32 register-file snapshot. It computes the result and presents it on `alu_result`. It sits between the instruction source and the register file. It never writes the register file; write-back is owned by the enclosing core.

---
 rtl/control_logic_pkg.sv | 45 ++++
 rtl/control_logic_pipe_alu.sv | 35 +++
 rtl/control_logic_pipe.sv | 152 +++++++++++++++
 tb/tb_control_logic_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_logic_pkg.sv
// Shared definitions for the three-stage RV32I ALU pipeline:
// opcode and funct constants, the ALU operation encoding, and
// a small immediate helper used by the decoder.
package control_logic_pkg;

    localparam int XLEN = 32;

    // Major opcodes handled by the pipeline; every other opcode is a bubble.
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    // funct3 values shared by R-type and I-type ALU instructions.
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7 (or imm[11:5] for immediate shifts): base and alternate forms.
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU operation encoding carried from decode into execute.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    // Sign-extend a 12-bit I-type immediate to the datapath width.
    function automatic logic [XLEN-1:0] sext_imm12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/control_logic_pipe_alu.sv
// Purely combinational RV32I integer ALU used in the execute stage.
// Add/sub wrap modulo 2^32, shifts use b[4:0], set-less-than yields 0/1.
module rv_alu
    import control_logic_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         alu_op,
    output logic [XLEN-1:0] y
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    // Select the result for the requested operation.
    always_comb begin
        // NOTE: y gets a default before the case so no path leaves it unassigned (no latch).
        y = '0;
        case (alu_op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << shamt;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $unsigned($signed(a) >>> shamt);
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/control_logic_pipe.sv
// Three-stage RV32I integer ALU pipeline.
//   Stage 1: decode the instruction, read operands from the register-file
//            snapshot, latch operands, ALU op and a valid bit.
//   Stage 2: execute in rv_alu, latch result and valid bit.
//   Stage 3: load alu_result only for valid results; bubbles hold it.
// Write-back is owned by the enclosing core; this block never writes reg_file.
module control_logic_pipe
    import control_logic_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] instruction,
    input  logic [XLEN-1:0] reg_file [32],
    output logic [XLEN-1:0] alu_result
);

    // Instruction fields.
    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instruction[6:0];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    // Register reads; x0 is hard-wired to zero whatever the snapshot holds.
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_val;

    assign rs1_val = (rs1 == 5'd0) ? '0 : reg_file[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : reg_file[rs2];
    assign imm_val = sext_imm12(instruction[31:20]);

    // Stage-1 next state (decode outputs) and registers.
    logic            s1_valid_d, s1_valid_q;
    alu_op_t         s1_op_d,    s1_op_q;
    logic [XLEN-1:0] s1_a_d,     s1_a_q;
    logic [XLEN-1:0] s1_b_d,     s1_b_q;

    // Stage-2 registers.
    logic            s2_valid_q;
    logic [XLEN-1:0] s2_result_d, s2_result_q;

    // Stage-3 output register.
    logic [XLEN-1:0] alu_result_q;

    // Decode: classify opcode, pick operand B and ALU op, flag illegal encodings as bubbles.
    always_comb begin
        s1_valid_d = 1'b0;
        s1_op_d    = ALU_ADD;
        s1_a_d     = rs1_val;
        s1_b_d     = rs2_val;

        case (opcode)
            OP_RTYPE: begin
                s1_b_d = rs2_val;
                // Only ADD/SUB and SRL/SRA have an alternate funct7 form.
                s1_valid_d = (funct7 == F7_BASE) ||
                             ((funct7 == F7_ALT) &&
                              ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR)));
                case (funct3)
                    F3_ADD_SUB: s1_op_d = funct7[5] ? ALU_SUB : ALU_ADD;
                    F3_SLL:     s1_op_d = ALU_SLL;
                    F3_SLT:     s1_op_d = ALU_SLT;
                    F3_SLTU:    s1_op_d = ALU_SLTU;
                    F3_XOR:     s1_op_d = ALU_XOR;
                    F3_SR:      s1_op_d = funct7[5] ? ALU_SRA : ALU_SRL;
                    F3_OR:      s1_op_d = ALU_OR;
                    F3_AND:     s1_op_d = ALU_AND;
                    default:    s1_op_d = ALU_ADD;
                endcase
            end

            OP_ITYPE: begin
                s1_b_d     = imm_val;
                s1_valid_d = 1'b1;
                case (funct3)
                    F3_ADD_SUB: s1_op_d = ALU_ADD;
                    F3_SLT:     s1_op_d = ALU_SLT;
                    F3_SLTU:    s1_op_d = ALU_SLTU;
                    F3_XOR:     s1_op_d = ALU_XOR;
                    F3_OR:      s1_op_d = ALU_OR;
                    F3_AND:     s1_op_d = ALU_AND;
                    F3_SLL: begin
                        // Immediate shifts carry the shift amount in imm[4:0];
                        // imm[11:5] must be a legal funct7 pattern.
                        s1_op_d    = ALU_SLL;
                        s1_valid_d = (funct7 == F7_BASE);
                    end
                    F3_SR: begin
                        s1_op_d    = funct7[5] ? ALU_SRA : ALU_SRL;
                        s1_valid_d = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    default: s1_op_d = ALU_ADD;
                endcase
            end

            default: s1_valid_d = 1'b0;
        endcase
    end

    // Stage 1: capture decoded operands so later reg_file changes cannot disturb this instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= ALU_ADD;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the pre-edge value of the one before it.
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
        end
    end

    rv_alu u_alu (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .alu_op (s1_op_q),
        .y      (s2_result_d)
    );

    // Stage 2: latch the execute result together with its valid bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
        end else begin
            s2_valid_q  <= s1_valid_q;
            s2_result_q <= s2_result_d;
        end
    end

    // Stage 3: update the visible result only for valid instructions; bubbles hold it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_result_q <= '0;
        end else if (s2_valid_q) begin
            alu_result_q <= s2_result_q;
        end
    end

    assign alu_result = alu_result_q;

endmodule

// File: tb/tb_control_logic_pipe.sv
// Self-checking bench for control_logic_pipe: directed steps from the
// intended use cases followed by randomized instructions checked against
// an instruction-level reference model with a two-deep latency queue.
module tb_control_logic_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] reg_file [32];
    logic [31:0] alu_result;

    int tests = 0;
    int fails = 0;

    control_logic_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .reg_file    (reg_file),
        .alu_result  (alu_result)
    );

    always #5 clk = ~clk;

    // Reference model: result of each sampled instruction, queued until it becomes visible.
    typedef struct {
        bit          v;
        logic [31:0] r;
    } ent_t;

    ent_t        pend[$];
    logic [31:0] exp_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] rd_reg(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : reg_file[idx];
    endfunction

    // Architectural result of one instruction against the current register snapshot.
    function automatic ent_t ref_exec(input logic [31:0] ins);
        ent_t        e;
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        bit          is_r;
        bit          legal;
        opc  = ins[6:0];
        f7   = ins[31:25];
        f3   = ins[14:12];
        e.v  = 1'b0;
        e.r  = 32'd0;
        is_r = (opc == 7'h33);
        if (!is_r && opc != 7'h13) return e;
        a = rd_reg(ins[19:15]);
        if (is_r) begin
            b     = rd_reg(ins[24:20]);
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        end else begin
            b = {{20{ins[31]}}, ins[31:20]};
            if (f3 == 3'd1)      legal = (f7 == 7'h00);
            else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
            else                 legal = 1'b1;
        end
        if (!legal) return e;
        sh = b[4:0];
        case (f3)
            3'd0: e.r = (is_r && f7[5]) ? a - b : a + b;
            3'd1: e.r = a << sh;
            3'd2: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: e.r = (a < b) ? 32'd1 : 32'd0;
            3'd4: e.r = a ^ b;
            3'd5: e.r = f7[5] ? $unsigned($signed(a) >>> sh) : a >> sh;
            3'd6: e.r = a | b;
            default: e.r = a & b;
        endcase
        e.v = 1'b1;
        return e;
    endfunction

    task automatic model_reset();
        ent_t idle;
        idle.v = 1'b0;
        idle.r = 32'd0;
        pend.delete();
        pend.push_back(idle);
        pend.push_back(idle);
        exp_q = 32'd0;
    endtask

    // One clock: drive instruction, advance the model at the edge, compare at the falling edge.
    task automatic step(input logic [31:0] ins);
        ent_t nxt;
        ent_t done;
        instruction = ins;
        nxt = ref_exec(ins);
        @(posedge clk);
        done = pend.pop_front();
        if (done.v) exp_q = done.r;
        pend.push_back(nxt);
        @(negedge clk);
        check("model", alu_result, exp_q);
    endtask

    // Issue one instruction, drain two bubbles, then compare with a known constant.
    task automatic run_single(input logic [31:0] ins, input string tag, input logic [31:0] expv);
        step(ins);
        step(32'd0);
        step(32'd0);
        check(tag, alu_result, expv);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 40));
            1:       return $urandom;
            2:       return 32'h8000_0000 | 32'($urandom_range(0, 3));
            default: return 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [6:0]  opc;
        int          kind;
        ins  = $urandom;
        f3   = ins[14:12];
        kind = $urandom_range(0, 9);
        if (kind <= 3) begin
            f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            ins[31:25] = f7;
            ins[6:0]   = 7'h33;
        end else if (kind <= 7) begin
            ins[6:0] = 7'h13;
            if (f3 == 3'd1 && $urandom_range(0, 3) != 0) ins[31:25] = 7'h00;
            if (f3 == 3'd5 && $urandom_range(0, 3) != 0)
                ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end else if (kind == 8) begin
            opc = ins[6:0];
            if (opc == 7'h33 || opc == 7'h13) opc = 7'h00;
            ins[6:0] = opc;
        end else begin
            f7 = ins[31:25];
            if (f7 == 7'h00 || f7 == 7'h20) f7 = 7'h01;
            ins[31:25] = f7;
            ins[6:0]   = 7'h33;
        end
        return ins;
    endfunction

    logic [31:0] stream_ins [5];
    logic [31:0] stream_exp [5];

    initial begin
        reset       = 1'b0;
        instruction = 32'd0;
        for (int i = 0; i < 32; i++) reg_file[i] = 32'd0;
        reg_file[1] = 32'd10;
        reg_file[2] = 32'd20;
        reg_file[3] = 32'd30;
        model_reset();

        // Reset held across one rising edge.
        @(negedge clk);
        check("reset_state", alu_result, 32'd0);
        reset = 1'b1;

        // Basic R-type and I-type results.
        run_single(32'h0020_8233, "add", 32'd30);
        run_single(32'h4020_82B3, "sub", 32'hFFFF_FFF6);
        run_single(32'hFFB1_8313, "addi", 32'd25);
        run_single(32'hFFF0_A393, "slti", 32'd0);
        run_single(32'hFFF0_B413, "sltiu", 32'd1);

        // Shifts of a negative value by x2 (low 5 bits = 20).
        reg_file[1] = 32'h8000_0000;
        run_single(32'h4020_D4B3, "sra", 32'hFFFF_F800);
        run_single(32'h0020_D4B3, "srl", 32'h0000_0800);
        reg_file[1] = 32'd10;

        // Back-to-back stream, one result per cycle.
        stream_ins = '{32'h0020_8233, 32'h4020_82B3, 32'h0020_F233, 32'h0020_E233, 32'h0020_C233};
        stream_exp = '{32'd30, 32'hFFFF_FFF6, 32'd0, 32'd30, 32'd30};
        for (int i = 0; i < 7; i++) begin
            step((i < 5) ? stream_ins[i] : 32'd0);
            if (i >= 2) check("stream", alu_result, stream_exp[i-2]);
        end

        // Bubble between two ADDs; x1 changes after the first ADD is sampled.
        step(32'h0020_8233);
        reg_file[1] = 32'd1;
        step(32'd0);
        step(32'h0020_8233);
        check("snapshot", alu_result, 32'd30);
        step(32'd0);
        check("bubble_hold", alu_result, 32'd30);
        step(32'd0);
        check("add_after_bubble", alu_result, 32'd21);
        reg_file[1] = 32'd10;

        // Reset mid-stream: asynchronous clear, in-flight work discarded.
        step(32'h0020_8233);
        step(32'h4020_82B3);
        #2 reset = 1'b0;
        #1 check("reset_async", alu_result, 32'd0);
        model_reset();
        @(negedge clk);
        check("reset_held", alu_result, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(32'd0);
            check("no_ghost", alu_result, 32'd0);
        end

        // x0 reads as zero even with a nonzero snapshot entry.
        reg_file[0] = 32'hDEAD_BEEF;
        run_single(32'h0020_0233, "x0_rs1", 32'd20);
        run_single(32'h0000_8233, "x0_rs2", 32'd10);
        run_single(32'h0050_0313, "x0_addi", 32'd5);

        // Illegal immediate-shift encoding is a bubble: result holds.
        run_single(32'h0200_9213, "slli_illegal", 32'd5);

        // Randomized instructions and register snapshots against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0)
                for (int i = 0; i < 32; i++) reg_file[i] = rand_val();
            step(rand_instr());
        end
        for (int i = 0; i < 3; i++) step(32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
